// File: rtl/t8051_pkg.sv
// Shared constants and helpers for the 8051 port bank.
package t8051_pkg;

  // Classic 8051 SFR addresses of P0..P3.
  localparam logic [7:0] P0_ADDR     = 8'h80;
  localparam logic [7:0] P1_ADDR     = 8'h90;
  localparam logic [7:0] P2_ADDR     = 8'hA0;
  localparam logic [7:0] P3_ADDR     = 8'hB0;
  localparam logic [7:0] PORT_STRIDE = 8'h10;

  // Number of bits needed to count up to v-1 (ceil(log2(v))).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/t8051_port.sv
// One quasi-bidirectional port: output latch, 2-flop input synchroniser,
// timed strong pull-up per bit, and falling-edge event detect.
module t8051_port
  import t8051_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int PULLUP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [WIDTH-1:0] i_pin,
  output logic [WIDTH-1:0] o_latch,
  output logic [WIDTH-1:0] o_pin_val,
  output logic [WIDTH-1:0] o_pin_out,
  output logic [WIDTH-1:0] o_pin_oe,
  output logic [WIDTH-1:0] o_fall_evt
);

  // Counter wide enough for PULLUP_CYCLES, never narrower than one bit.
  localparam int CW_RAW = clog2(PULLUP_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] LOAD = CW'(PULLUP_CYCLES);

  logic [WIDTH-1:0] r_latch;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [CW-1:0]    r_cnt [WIDTH];

  // Output latch: written by the core, idles high like an 8051 port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_latch <= '1;
    else if (i_wr) r_latch <= i_wdata;
  end

  // Strong pull-up timers: load on a 0->1 latch write, clear on a 0 write,
  // otherwise count down and hold at zero. A 1-over-1 write does not reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < WIDTH; b++) r_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (i_wr && i_wdata[b] && !r_latch[b]) r_cnt[b] <= LOAD;
        else if (i_wr && !i_wdata[b])          r_cnt[b] <= '0;
        else if (r_cnt[b] != '0)               r_cnt[b] <= r_cnt[b] - CW'(1);
      end
    end
  end

  // Two-flop synchroniser for the asynchronous pad inputs; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
    end
  end

  // Pad drive from registered state: low latch drives 0, a running timer
  // drives 1 strongly, otherwise the pad is left to the weak pull-up.
  always_comb begin
    for (int b = 0; b < WIDTH; b++) begin
      o_pin_oe[b] = ~r_latch[b] | (r_cnt[b] != '0);
    end
  end

  assign o_pin_out  = r_latch;
  assign o_latch    = r_latch;
  assign o_pin_val  = r_s2;
  assign o_fall_evt = r_s2 & ~r_s1;

endmodule

// File: rtl/t8051_port_bank.sv
// Bank of NUM_PORTS quasi-bidirectional ports on the SFR bus.
// Bus protocol: i_sfr_wr / i_sfr_rd are single-cycle strobes qualified by
// a decoded i_sfr_addr; there is no backpressure. A read strobe returns data
// in o_sfr_rdata after the next clock edge; o_sfr_rdata is 0 in any cycle
// not following a decoded read.
module t8051_port_bank
  import t8051_pkg::*;
#(
  parameter int          NUM_PORTS     = 4,
  parameter int          WIDTH         = 8,
  parameter logic [7:0]  BASE_ADDR     = P0_ADDR,
  parameter logic [7:0]  ADDR_STRIDE   = PORT_STRIDE,
  parameter int          PULLUP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 i_sfr_addr,
  input  logic                       i_sfr_wr,
  input  logic [WIDTH-1:0]           i_sfr_wdata,
  input  logic                       i_sfr_rd,
  input  logic                       i_sfr_rmw,
  output logic                       o_sfr_hit,
  output logic [WIDTH-1:0]           o_sfr_rdata,
  input  logic [NUM_PORTS*WIDTH-1:0] i_pin_in,
  output logic [NUM_PORTS*WIDTH-1:0] o_pin_out,
  output logic [NUM_PORTS*WIDTH-1:0] o_pin_oe,
  output logic [NUM_PORTS*WIDTH-1:0] o_fall_evt
);

  logic [NUM_PORTS-1:0] w_sel;
  logic [WIDTH-1:0]     w_latch   [NUM_PORTS];
  logic [WIDTH-1:0]     w_pin_val [NUM_PORTS];
  logic [WIDTH-1:0]     w_rd_val;
  logic [WIDTH-1:0]     r_rdata;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    localparam logic [7:0] ADDR_K = 8'(int'(BASE_ADDR) + k * int'(ADDR_STRIDE));

    assign w_sel[k] = (i_sfr_addr == ADDR_K);

    t8051_port #(
      .WIDTH         (WIDTH),
      .PULLUP_CYCLES (PULLUP_CYCLES)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .i_wr       (i_sfr_wr & w_sel[k]),
      .i_wdata    (i_sfr_wdata),
      .i_pin      (i_pin_in[k*WIDTH +: WIDTH]),
      .o_latch    (w_latch[k]),
      .o_pin_val  (w_pin_val[k]),
      .o_pin_out  (o_pin_out[k*WIDTH +: WIDTH]),
      .o_pin_oe   (o_pin_oe[k*WIDTH +: WIDTH]),
      .o_fall_evt (o_fall_evt[k*WIDTH +: WIDTH])
    );
  end

  assign o_sfr_hit = |w_sel;

  // Read mux: RMW instructions see the latch, plain reads see the pins.
  always_comb begin
    w_rd_val = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (w_sel[k]) w_rd_val = i_sfr_rmw ? w_latch[k] : w_pin_val[k];
    end
  end

  // Registered read data; pre-write value on a same-cycle read+write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rdata <= '0;
    else if (i_sfr_rd && o_sfr_hit) r_rdata <= w_rd_val;
    else r_rdata <= '0;
  end

  assign o_sfr_rdata = r_rdata;

endmodule
